pwm_audio_stereo_in: RTL and testbench
======================================

# pwm_audio_stereo_in

Stereo PWM audio capture. Measures the duty cycle of two incoming 1-bit PWM streams over fixed 2^WIDTH-cycle frames and delivers one WIDTH-bit sample pair per frame on a valid/ready interface. It is the receive-side counterpart of `pwm_audio_stereo_out`: a stream it generates from `left_top`/`right_top` is recovered here as `left_sample`/`right_sample`. Used for loopback test and for capturing external PWM/1-bit audio sources.

## Interface
Parameters:
- `WIDTH`, 8: sample width; frame length is 2^WIDTH clocks.

Ports:
- `clk` in 1: sole clock; all logic is rising-edge.
- `aclr` in 1: reset, synchronous, active-low.
- `left` in 1: left PWM input, asynchronous to `clk` when `PWM_IN_SYNC_EN` is defined.
- `right` in 1: right PWM input, same rules as `left`.
- `left_sample` out WIDTH: left duty sample, unsigned high-cycle count per frame.
- `right_sample` out WIDTH: right duty sample.
- `sample_valid` out 1: sample pair is available; held until accepted.
- `sample_ready` in 1: consumer accepts the pair on a clock edge where `sample_valid` and `sample_ready` are both 1.
- `overrun` out 1: sticky flag; a frame completed while the previous pair was still unaccepted.

## Operation
- `frame_cnt` is a free-running WIDTH-bit counter, 0 to 2^WIDTH−1, wrapping to 0.
- Per channel, a (WIDTH+1)-bit accumulator `acc` increments on every cycle where the conditioned input is 1.
- Frame end is the cycle where `frame_cnt` = 2^WIDTH−1. On that edge:
  - `acc_final` = `acc` + the current input.
  - The sample register loads `min(acc_final, 2^WIDTH−1)`. A constantly high input therefore reads 255 at WIDTH=8, not 256.
  - `acc` clears to 0.
  - `sample_valid` is set to 1.
- Handshake:
  - When `sample_valid`=1 and `sample_ready`=1 at an edge with no frame end, `sample_valid` clears.
  - `sample_ready` is ignored while `sample_valid`=0.
- Frame end with `sample_valid`=1 and `sample_ready`=0:
  - The samples are overwritten with the new frame's values.
  - `sample_valid` stays 1.
  - `overrun` sets to 1.
- Frame end on the same edge as an accepting handshake:
  - The new samples load and `sample_valid` stays 1.
  - `overrun` is not set.
- `overrun` clears only on reset.
- Measurement is phase-independent. A steady periodic PWM of period 2^WIDTH gives the exact duty count regardless of its alignment with `frame_cnt`.

## Timing
- Reset (`aclr`=0 at an edge) forces these to 0: `frame_cnt`, both `acc`, `left_sample`, `right_sample`, `sample_valid`, `overrun`, and the synchronizer flops.
- Reset asserted mid-frame discards the partial frame and any pending sample; no partial sample is emitted.
- `frame_cnt` = 0 on the first edge after `aclr` returns to 1.
- The first `sample_valid` rises 2^WIDTH cycles after reset release (256 at WIDTH=8).
- Input-to-count latency:
  - 2 cycles with `PWM_IN_SYNC_EN` defined.
  - 0 cycles without it.
- With the synchronizer, the first frame after reset includes 2 reset-zero cycles in place of real input.
- Sample-to-output latency: 1 cycle after the frame-end edge, because outputs are registered.
- The accumulator never exceeds 2^WIDTH, so WIDTH+1 bits are sufficient.

## Configuration
- `PWM_IN_SYNC_EN` defined:
  - A 2-flop synchronizer on each of `left` and `right`; inputs may be asynchronous.
- Not defined:
  - Inputs are sampled directly and must be synchronous to `clk`, e.g. in a loopback from `pwm_audio_stereo_out` on the same clock.
  - Zero added latency and no synchronizer flops.

## Structure
- Shared package `pwm_audio_pkg`:
  - Default `WIDTH`.
  - The frame-end constant 2^WIDTH−1.
  - A saturate-to-WIDTH function.
  - All of these are also used by `pwm_audio_stereo_out`.
- Sub-module `pwm_duty_counter`, instantiated once per channel:
  - Contains the optional synchronizer, the accumulator, saturation, and the sample register.
  - Takes `frame_end` from the top level.
- The top level owns `frame_cnt`, the valid/ready logic and `overrun`.

## Test plan
- Left PWM high for 127 of every 256 cycles, right low, `sample_ready`=1 → each pair reads `left_sample`=127, `right_sample`=0, with `sample_valid` pulsing for 1 cycle per frame.
- Both inputs constantly 1 → both samples = 255 (saturated); constantly 0 → both = 0.
- `sample_ready`=0 across two frame ends with left duty changing from 64 to 200 → `left_sample`=200, `sample_valid` held at 1, `overrun`=1. Raising `sample_ready` for 1 cycle then clears `sample_valid` while `overrun` stays 1.
- Handshake on the exact frame-end edge → `sample_valid` stays 1, new values load, `overrun`=0.
- Reset pulsed at cycle 100 of a frame → all outputs 0 on the next edge; the first `sample_valid` arrives 256 cycles after release.
- Loopback from `pwm_audio_stereo_out` (same clk, macro undefined) with left 127 then right 127 → after one settling frame, the captured samples match the driven values exactly.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// rtl/pwm_audio_pkg.sv - shared constants and helpers for the PWM audio in/out blocks
// Default sample width, frame-end constant and saturate-to-width helper.
package pwm_audio_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int SAT_MAXW      = 16;
  localparam int EXTW          = SAT_MAXW + 1;
  localparam int FRAME_END     = (1 << DEFAULT_WIDTH) - 1;

  // Largest value representable in w bits, i.e. the last frame_cnt value.
  function automatic logic [SAT_MAXW-1:0] frame_end_of(input int w);
    logic [EXTW-1:0] lim;
    lim = (EXTW'(1) << w) - EXTW'(1);
    return lim[SAT_MAXW-1:0];
  endfunction

  function automatic logic [SAT_MAXW-1:0] sat_to_width(input logic [EXTW-1:0] a, input int w);
    logic [EXTW-1:0] lim;
    lim = (EXTW'(1) << w) - EXTW'(1);
    return (a > lim) ? lim[SAT_MAXW-1:0] : a[SAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_counter.sv
// rtl/pwm_duty_counter.sv - per-channel high-cycle accumulator and saturated sample register
// Optional 2-flop input synchronizer under PWM_IN_SYNC_EN.
module pwm_duty_counter
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             pwm_in,
  input  logic             frame_end,
  output logic [WIDTH-1:0] sample
);

  logic w_bit;

`ifdef PWM_IN_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!aclr) r_sync <= '0;
    else       r_sync <= {r_sync[0], pwm_in};
  end

  assign w_bit = r_sync[1];
`else
  assign w_bit = pwm_in;
`endif

  logic [WIDTH:0]    r_acc;
  logic [WIDTH-1:0]  r_sample;
  logic [WIDTH:0]    w_acc_final;
  logic [SAT_MAXW-1:0] w_sat;
  logic              w_unused_sat;

  // The frame-end cycle's own input bit is folded in before saturating.
  assign w_acc_final  = r_acc + {{WIDTH{1'b0}}, w_bit};
  assign w_sat        = sat_to_width({{(SAT_MAXW-WIDTH){1'b0}}, w_acc_final}, WIDTH);
  assign w_unused_sat = |w_sat[SAT_MAXW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!aclr) begin
      r_acc    <= '0;
      r_sample <= '0;
    end else if (frame_end) begin
      r_acc    <= '0;
      r_sample <= w_sat[WIDTH-1:0];
    end else if (w_bit) begin
      r_acc    <= r_acc + (WIDTH+1)'(1);
    end
  end

  assign sample = r_sample;

endmodule

// File: rtl/pwm_audio_stereo_in.sv
// rtl/pwm_audio_stereo_in.sv - stereo PWM duty capture with valid/ready sample output
// Define PWM_IN_SYNC_EN to add a 2-flop synchronizer on each PWM input.
module pwm_audio_stereo_in
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             left,
  input  logic             right,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] r_frame_cnt;
  logic             r_valid;
  logic             r_overrun;
  logic             w_frame_end;

  assign w_frame_end = ({{(SAT_MAXW-WIDTH){1'b0}}, r_frame_cnt} == frame_end_of(WIDTH));

  // A new frame always wins over a handshake; overrun only if the old pair was not taken.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      r_frame_cnt <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_cnt <= r_frame_cnt + WIDTH'(1);
      if (w_frame_end) begin
        r_valid <= 1'b1;
        if (r_valid && !sample_ready) r_overrun <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  pwm_duty_counter #(.WIDTH(WIDTH)) u_left (
    .clk       (clk),
    .aclr      (aclr),
    .pwm_in    (left),
    .frame_end (w_frame_end),
    .sample    (left_sample)
  );

  pwm_duty_counter #(.WIDTH(WIDTH)) u_right (
    .clk       (clk),
    .aclr      (aclr),
    .pwm_in    (right),
    .frame_end (w_frame_end),
    .sample    (right_sample)
  );

  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_pwm_audio_stereo_in.sv
// tb/tb_pwm_audio_stereo_in.sv - directed table-driven bench for pwm_audio_stereo_in
// Built with PWM_IN_SYNC_EN undefined (zero input latency).
module tb_pwm_audio_stereo_in;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       sample_ready = 1'b0;
  logic [7:0] left_sample;
  logic [7:0] right_sample;
  logic       sample_valid;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;
  int ph      = 0;
  int n_valid = 0;
  int l_duty  = 0;
  int r_duty  = 0;
  int l_off   = 0;
  int r_off   = 0;

  typedef struct {
    int l_duty;
    int r_duty;
    int l_off;
    int r_off;
    int exp_l;
    int exp_r;
  } vec_t;

  vec_t vecs[6];

  pwm_audio_stereo_in #(.WIDTH(8)) dut (
    .clk          (clk),
    .aclr         (aclr),
    .left         (left),
    .right        (right),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ph mirrors the frame position of the edge about to happen.
  task automatic step();
    left  = (((ph - l_off + 256) % 256) < l_duty);
    right = (((ph - r_off + 256) % 256) < r_duty);
    @(posedge clk);
    #1;
    if (!aclr) ph = 0;
    else       ph = (ph + 1) % 256;
    if (sample_valid) n_valid++;
  endtask

  task automatic run_to_end();
    n_valid = 0;
    do step(); while (ph != 0);
  endtask

  initial begin
    vecs[0] = '{127,   0,   0,   0, 127,   0};
    vecs[1] = '{256, 256,   0,   0, 255, 255};
    vecs[2] = '{  0,   0,   0,   0,   0,   0};
    vecs[3] = '{  1, 255,   0,   0,   1, 255};
    vecs[4] = '{127, 200,  50, 200, 127, 200};
    vecs[5] = '{255,   1, 255, 128, 255,   1};

    aclr = 1'b0;
    repeat (3) step();
    chk("rst_left", int'(left_sample), 0);
    chk("rst_right", int'(right_sample), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_overrun", int'(overrun), 0);

    aclr = 1'b1;
    sample_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      l_duty = vecs[i].l_duty;
      r_duty = vecs[i].r_duty;
      l_off  = vecs[i].l_off;
      r_off  = vecs[i].r_off;
      run_to_end();
      chk($sformatf("vec%0d_valid", i), int'(sample_valid), 1);
      chk($sformatf("vec%0d_left", i), int'(left_sample), vecs[i].exp_l);
      chk($sformatf("vec%0d_right", i), int'(right_sample), vecs[i].exp_r);
      chk($sformatf("vec%0d_pulse", i), n_valid, 1);
    end

    l_duty = 64; r_duty = 10; l_off = 0; r_off = 0;
    step();
    chk("ack_clear_valid", int'(sample_valid), 0);
    sample_ready = 1'b0;
    run_to_end();
    chk("ovr1_valid", int'(sample_valid), 1);
    chk("ovr1_left", int'(left_sample), 64);
    chk("ovr1_overrun", int'(overrun), 0);
    l_duty = 200;
    run_to_end();
    chk("ovr2_left", int'(left_sample), 200);
    chk("ovr2_valid", int'(sample_valid), 1);
    chk("ovr2_overrun", int'(overrun), 1);
    chk("ovr2_held", n_valid, 256);
    sample_ready = 1'b1;
    step();
    chk("ovr_ack_valid", int'(sample_valid), 0);
    chk("ovr_ack_overrun", int'(overrun), 1);

    while (ph != 100) step();
    aclr = 1'b0;
    step();
    chk("midrst_left", int'(left_sample), 0);
    chk("midrst_right", int'(right_sample), 0);
    chk("midrst_valid", int'(sample_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);

    aclr = 1'b1;
    sample_ready = 1'b0;
    l_duty = 30; r_duty = 90;
    n_valid = 0;
    repeat (255) step();
    chk("post_rst_early_valid", n_valid, 0);
    step();
    chk("post_rst_valid", int'(sample_valid), 1);
    chk("post_rst_left", int'(left_sample), 30);
    chk("post_rst_right", int'(right_sample), 90);
    chk("post_rst_overrun", int'(overrun), 0);

    l_duty = 77; r_duty = 160;
    repeat (255) step();
    chk("fe_hs_held", int'(sample_valid), 1);
    sample_ready = 1'b1;
    step();
    chk("fe_hs_valid", int'(sample_valid), 1);
    chk("fe_hs_left", int'(left_sample), 77);
    chk("fe_hs_right", int'(right_sample), 160);
    chk("fe_hs_overrun", int'(overrun), 0);
    step();
    chk("fe_hs_ack", int'(sample_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
